// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width, ALU opcodes and queue command codes.
package calc_pkg;

    localparam int DATA_W = 8;

    // ALU opcodes
    localparam logic [2:0] ALU_PUSH = 3'd0;
    localparam logic [2:0] ALU_POP  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_MULL = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;
    localparam logic [2:0] ALU_DIV  = 3'd5;
    localparam logic [2:0] ALU_REM  = 3'd6;

    // Queue commands issued by the ALU
    typedef enum logic [1:0] {
        Q_PUSH         = 2'b00,
        Q_SLEEP        = 2'b01,
        Q_GET_AND_PUSH = 2'b10,
        Q_POP          = 2'b11
    } queue_op_e;

endpackage

// File: rtl/queue_ram.sv
// Operand storage: one synchronous write port, two asynchronous read ports.
module queue_ram
    import calc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr0,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/calc_queue.sv
// Circular operand queue behind the calculator ALU.
// Occupancy is tracked by count; head/tail wrap naturally at ADDR_W bits.
module calc_queue
    import calc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_valid,
    input  logic [1:0]                queue_op,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      calc_err,
    output logic [2*DATA_W-1:0]       operands,
    output logic [DATA_W-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      op_done,
    output logic                      err_ovf,
    output logic                      err_unf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] C_TWO   = (ADDR_W+1)'(2);

    logic [ADDR_W-1:0] r_head, r_tail;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_op_done, r_err_ovf, r_err_unf, r_empty, r_full;

    logic [ADDR_W-1:0] w_head1, w_head_nxt, w_tail_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic [DATA_W-1:0] w_rd0, w_rd1;
    logic              w_accept, w_we, w_pop_ld, w_ovf_set, w_unf_set;

    assign w_head1 = r_head + ADDR_W'(1);

    // A write issued in a reset cycle must not reach the array.
    queue_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk      (clk),
        .i_we     (w_we & rst),
        .i_waddr  (r_tail),
        .i_wdata  (wr_data),
        .i_raddr0 (r_head),
        .i_raddr1 (w_head1),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    // Command decode, legality check and next pointer/count values.
    always_comb begin
        w_accept    = 1'b0;
        w_we        = 1'b0;
        w_pop_ld    = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (op_valid && !calc_err) begin
            case (queue_op_e'(queue_op))
                Q_PUSH: begin
                    if (r_count != C_DEPTH) begin
                        w_accept    = 1'b1;
                        w_we        = 1'b1;
                        w_tail_nxt  = r_tail + ADDR_W'(1);
                        w_count_nxt = r_count + C_ONE;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
                Q_POP: begin
                    if (r_count != '0) begin
                        w_accept    = 1'b1;
                        w_pop_ld    = 1'b1;
                        w_head_nxt  = w_head1;
                        w_count_nxt = r_count - C_ONE;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                Q_GET_AND_PUSH: begin
                    // When full, the slot written is the old head being freed.
                    if (r_count >= C_TWO) begin
                        w_accept    = 1'b1;
                        w_we        = 1'b1;
                        w_head_nxt  = r_head + ADDR_W'(2);
                        w_tail_nxt  = r_tail + ADDR_W'(1);
                        w_count_nxt = r_count - C_ONE;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered status update; reset overrides any command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
            r_op_done  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
        end else begin
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_op_done <= w_accept;
            r_err_ovf <= r_err_ovf | w_ovf_set;
            r_err_unf <= r_err_unf | w_unf_set;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == C_DEPTH);
            if (w_pop_ld) begin
                r_pop_data <= w_rd0;
            end
        end
    end

    assign operands = {(r_count >= C_TWO) ? w_rd1 : {DATA_W{1'b0}},
                       (r_count != '0)    ? w_rd0 : {DATA_W{1'b0}}};
    assign pop_data = r_pop_data;
    assign count    = r_count;
    assign empty    = r_empty;
    assign full     = r_full;
    assign op_done  = r_op_done;
    assign err_ovf  = r_err_ovf;
    assign err_unf  = r_err_unf;

endmodule

// File: tb/tb_calc_queue.sv
// Bench for calc_queue: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_calc_queue;
    import calc_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  queue_op = 2'b01;
    logic [7:0]  wr_data = '0;
    logic        calc_err = 1'b0;
    logic [15:0] operands;
    logic [7:0]  pop_data;
    logic [3:0]  count;
    logic        empty, full, op_done, err_ovf, err_unf;

    int checks = 0;
    int failures = 0;

    calc_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .queue_op (queue_op),
        .wr_data  (wr_data),
        .calc_err (calc_err),
        .operands (operands),
        .pop_data (pop_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .op_done  (op_done),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a plain queue.
    logic [7:0] m_q[$];
    logic [7:0] m_pop;
    bit         m_done, m_ovf, m_unf, m_live;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_pop  = 8'h00;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_done = 1'b0;
            if (op_valid && !calc_err) begin
                case (queue_op)
                    2'b00: if (m_q.size() < DEPTH) begin m_q.push_back(wr_data); m_done = 1'b1; end
                           else m_ovf = 1'b1;
                    2'b11: if (m_q.size() >= 1) begin m_pop = m_q.pop_front(); m_done = 1'b1; end
                           else m_unf = 1'b1;
                    2'b10: if (m_q.size() >= 2) begin
                               void'(m_q.pop_front());
                               void'(m_q.pop_front());
                               m_q.push_back(wr_data);
                               m_done = 1'b1;
                           end else m_unf = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Compare process: every cycle once the model is anchored by reset.
    always @(negedge clk) begin
        if (m_live) begin
            logic [15:0] exp_ops;
            exp_ops[7:0]  = (m_q.size() >= 1) ? m_q[0] : 8'h00;
            exp_ops[15:8] = (m_q.size() >= 2) ? m_q[1] : 8'h00;
            chk("count",    32'(count),    32'(m_q.size()));
            chk("empty",    32'(empty),    32'(m_q.size() == 0));
            chk("full",     32'(full),     32'(m_q.size() == DEPTH));
            chk("operands", 32'(operands), 32'(exp_ops));
            chk("pop_data", 32'(pop_data), 32'(m_pop));
            chk("op_done",  32'(op_done),  32'(m_done));
            chk("err_ovf",  32'(err_ovf),  32'(m_ovf));
            chk("err_unf",  32'(err_unf),  32'(m_unf));
        end
    end

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] d,
                        input logic e, input logic r);
        op_valid = v;
        queue_op = op;
        wr_data  = d;
        calc_err = e;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, Q_SLEEP, 8'h00, 1'b0, 1'b0);
    endtask

    int done_cnt;

    initial begin
        do_reset();
        do_reset();
        chk("lit_reset_count", 32'(count), 32'd0);
        chk("lit_reset_empty", 32'(empty), 32'd1);

        // Push 5, 3, 7
        done_cnt = 0;
        step(1'b1, Q_PUSH, 8'd5, 1'b0, 1'b1); done_cnt += int'(op_done);
        step(1'b1, Q_PUSH, 8'd3, 1'b0, 1'b1); done_cnt += int'(op_done);
        step(1'b1, Q_PUSH, 8'd7, 1'b0, 1'b1); done_cnt += int'(op_done);
        chk("lit_push3_done_pulses", 32'(done_cnt), 32'd3);
        chk("lit_push3_count", 32'(count), 32'd3);
        chk("lit_push3_operands", 32'(operands), 32'h0305);
        chk("lit_push3_empty", 32'(empty), 32'd0);

        step(1'b1, Q_GET_AND_PUSH, 8'd8, 1'b0, 1'b1);
        chk("lit_gap_count", 32'(count), 32'd2);
        chk("lit_gap_operands", 32'(operands), 32'h0807);

        // Fill, overflow, then get-and-push when full
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, Q_PUSH, 8'(i), 1'b0, 1'b1);
        step(1'b1, Q_PUSH, 8'd9, 1'b0, 1'b1);
        chk("lit_ovf_full", 32'(full), 32'd1);
        chk("lit_ovf_flag", 32'(err_ovf), 32'd1);
        chk("lit_ovf_count", 32'(count), 32'd8);
        chk("lit_ovf_done", 32'(op_done), 32'd0);
        step(1'b1, Q_GET_AND_PUSH, 8'd3, 1'b0, 1'b1);
        chk("lit_fullgap_count", 32'(count), 32'd7);
        chk("lit_fullgap_operands", 32'(operands), 32'h0403);
        for (int i = 0; i < 6; i++) step(1'b1, Q_POP, 8'h00, 1'b0, 1'b1);
        chk("lit_wrap_pop", 32'(pop_data), 32'd8);
        chk("lit_wrap_operands", 32'(operands), 32'h0003);

        // Underflow cases
        do_reset();
        step(1'b1, Q_POP, 8'h00, 1'b0, 1'b1);
        chk("lit_unf_flag", 32'(err_unf), 32'd1);
        chk("lit_unf_pop", 32'(pop_data), 32'd0);
        step(1'b1, Q_PUSH, 8'd9, 1'b0, 1'b1);
        step(1'b1, Q_GET_AND_PUSH, 8'd1, 1'b0, 1'b1);
        chk("lit_gap1_count", 32'(count), 32'd1);
        chk("lit_gap1_done", 32'(op_done), 32'd0);
        step(1'b1, Q_POP, 8'h00, 1'b0, 1'b1);
        chk("lit_pop9", 32'(pop_data), 32'd9);
        chk("lit_pop9_empty", 32'(empty), 32'd1);

        // Suppressed commands
        do_reset();
        step(1'b1, Q_PUSH, 8'd6, 1'b1, 1'b1);
        chk("lit_calcerr_count", 32'(count), 32'd0);
        chk("lit_calcerr_flags", 32'({err_ovf, err_unf, op_done}), 32'd0);
        step(1'b0, Q_PUSH, 8'd6, 1'b0, 1'b1);
        step(1'b0, Q_POP, 8'd6, 1'b0, 1'b1);
        chk("lit_novalid_count", 32'(count), 32'd0);
        step(1'b1, Q_SLEEP, 8'd6, 1'b0, 1'b1);
        chk("lit_sleep_done", 32'(op_done), 32'd0);

        // Reset concurrent with a push
        for (int i = 0; i < 4; i++) step(1'b1, Q_PUSH, 8'(i + 20), 1'b0, 1'b1);
        step(1'b1, Q_POP, 8'h00, 1'b0, 1'b1);
        step(1'b1, Q_PUSH, 8'd99, 1'b0, 1'b0);
        chk("lit_rstpush_count", 32'(count), 32'd0);
        chk("lit_rstpush_operands", 32'(operands), 32'd0);
        chk("lit_rstpush_flags", 32'({pop_data, op_done, err_ovf, err_unf}), 32'd0);
        step(1'b1, Q_PUSH, 8'd2, 1'b0, 1'b1);
        chk("lit_after_rst_op0", 32'(operands[7:0]), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 9) < 8),
                 2'($urandom_range(0, 3)),
                 8'($urandom),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 199) != 0));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
